// File: rtl/pe_mac_vec_pkg.sv
// Shared types and sizing helpers for the vector multiply-accumulate PE.
package pe_mac_vec_pkg;

  typedef enum logic [1:0] {
    StAcc,
    StFlush,
    StOut
  } state_e;

  // Width of an exact dot-product sum of one beat.
  function automatic int acc_bw_min(input int lanes, input int weight_bw, input int data_bw);
    return weight_bw + data_bw + $clog2(lanes);
  endfunction

endpackage

// File: rtl/pe_mac_vec_weight_reg.sv
// One lane's weight register; loads whenever reload is asserted.
module pe_mac_vec_weight_reg #(
  parameter int WEIGHT_BW = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic [WEIGHT_BW-1:0] d,
  output logic [WEIGHT_BW-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pe_mac_vec.sv
// Three-stage signed dot-product accumulator with valid/ready on both sides.
module pe_mac_vec
  import pe_mac_vec_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int WEIGHT_BW = 8,
  parameter int DATA_BW   = 8,
  parameter int ACC_BW    = 24
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         weight_reload,
  input  logic [LANES*WEIGHT_BW-1:0]   weight_in,
  input  logic                         sat_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DATA_BW-1:0]     data_in,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_BW-1:0]            acc_out,
  output logic                         overflow
);

  localparam int PROD_BW = WEIGHT_BW + DATA_BW;
  localparam int SUM_BW  = acc_bw_min(LANES, WEIGHT_BW, DATA_BW);
  localparam int WIDE_BW = ((ACC_BW > SUM_BW) ? ACC_BW : SUM_BW) + 1;
  localparam logic signed [WIDE_BW-1:0] AccMax =
    {{(WIDE_BW-ACC_BW+1){1'b0}}, {(ACC_BW-1){1'b1}}};
  localparam logic signed [WIDE_BW-1:0] AccMin =
    {{(WIDE_BW-ACC_BW+1){1'b1}}, {(ACC_BW-1){1'b0}}};
  // Stage 3 writes two edges after the last beat; one more edge lets acc_q settle.
  localparam logic [1:0] FlushLast = 2'd2;

  logic [LANES*WEIGHT_BW-1:0] weight_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_mac_vec_weight_reg #(
      .WEIGHT_BW(WEIGHT_BW)
    ) u_weight_reg (
      .clk (clk),
      .rstn(rstn),
      .load(weight_reload),
      .d   (weight_in[i*WEIGHT_BW +: WEIGHT_BW]),
      .q   (weight_q[i*WEIGHT_BW +: WEIGHT_BW])
    );
  end

  state_e                     state_q;
  logic [1:0]                 flush_cnt_q;
  logic                       in_ready_q, out_valid_q, first_q;
  logic                       s1_valid_q, s1_first_q, s2_valid_q, s2_first_q;
  logic signed [PROD_BW-1:0]  prod_d [LANES];
  logic signed [PROD_BW-1:0]  s1_prod_q [LANES];
  logic signed [SUM_BW-1:0]   sum_d, s2_sum_q;
  logic signed [ACC_BW-1:0]   acc_q, acc_d;
  logic signed [WIDE_BW-1:0]  base, total;
  logic                       ovf_q, ovf_beat, accept;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = PROD_BW'($signed(weight_q[i*WEIGHT_BW +: WEIGHT_BW])) *
                  PROD_BW'($signed(data_in[i*DATA_BW +: DATA_BW]));
    end
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_BW'(s1_prod_q[i]);
    end
  end

  always_comb begin
    base     = s2_first_q ? '0 : WIDE_BW'(acc_q);
    total    = base + WIDE_BW'(s2_sum_q);
    ovf_beat = (total > AccMax) || (total < AccMin);
    acc_d    = total[ACC_BW-1:0];
    if (ovf_beat && sat_en) begin
      acc_d = (total > AccMax) ? AccMax[ACC_BW-1:0] : AccMin[ACC_BW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first_q    <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_sum_q   <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_prod_q[i] <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        first_q    <= in_last;
        s1_first_q <= first_q;
        s1_prod_q  <= prod_d;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_first_q <= s1_first_q;
        s2_sum_q   <= sum_d;
      end
      if (s2_valid_q) begin
        acc_q <= acc_d;
        ovf_q <= s2_first_q ? ovf_beat : (ovf_q | ovf_beat);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StAcc;
      flush_cnt_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StAcc: begin
          if (accept && in_last) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
            in_ready_q  <= 1'b0;
          end
        end
        StFlush: begin
          if (flush_cnt_q == FlushLast) begin
            state_q     <= StOut;
            out_valid_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + 2'd1;
          end
        end
        StOut: begin
          if (out_ready) begin
            state_q     <= StAcc;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StAcc;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;

endmodule
